// File: rtl/serial_adder_pkg.sv
// Shared types and configuration checks for the multi-cycle serial adder.
// Imported by the top and the digit adder.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Legal when the operand splits into a whole number of digits.
  function automatic bit digit_cfg_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder with carry in/out; the reusable
// building block that the serial adder iterates over.
module digit_adder
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};

endmodule

// File: rtl/serial_adder.sv
// Serial adder: sums a + b + cin over WIDTH/DIGIT clocks using one digit adder.
// Handshake: start is taken only in IDLE; busy is high during RUN; done pulses
// for one cycle on the edge that updates sum/carry, which otherwise hold.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CW = $clog2(NUM_DIGITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

  if (!digit_cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dig;
  logic             cout;
  logic [WIDTH-1:0] dig_ext;
  logic [WIDTH-1:0] acc_next;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x  (a_sh[DIGIT-1:0]),
    .y  (b_sh[DIGIT-1:0]),
    .ci (c),
    .s  (dig),
    .co (cout)
  );

  // New digit enters at the top so the LSB digit ends up at bit 0 after N steps.
  assign dig_ext  = WIDTH'(dig);
  assign acc_next = (acc >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
  assign busy     = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          acc  <= acc_next;
          c    <= cout;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= acc_next;
            carry <= cout;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a 16/4 instance plus 8/8 and 8/1 instances, random
// and directed operations checked against plain a+b+cin arithmetic.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 16-bit, 4-bit digit instance
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic        busy16, done16, carry16;
  logic [15:0] sum16;

  // 8-bit single-digit instance (sel 0) and 8-bit bit-serial instance (sel 1)
  logic       start8 [2];
  logic [7:0] a8 [2];
  logic [7:0] b8 [2];
  logic       cin8 [2];
  logic       busy8 [2];
  logic       done8 [2];
  logic       carry8 [2];
  logic [7:0] sum8 [2];

  int total = 0;
  int bad = 0;

  logic [15:0] last_sum16 = '0;
  logic        last_carry16 = 1'b0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .carry(carry16)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut_w8d8 (
    .clk(clk), .rst(rst), .start(start8[0]), .a(a8[0]), .b(b8[0]), .cin(cin8[0]),
    .busy(busy8[0]), .done(done8[0]), .sum(sum8[0]), .carry(carry8[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut_w8d1 (
    .clk(clk), .rst(rst), .start(start8[1]), .a(a8[1]), .b(b8[1]), .cin(cin8[1]),
    .busy(busy8[1]), .done(done8[1]), .sum(sum8[1]), .carry(carry8[1])
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // One 16-bit operation. Inputs are driven on the falling edge; the accepting
  // edge follows. Returns on the falling edge where done is expected high, so a
  // caller may assert start again immediately. repulse_at >= 0 re-asserts start
  // with a different operand at that cycle of the run.
  task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                      input int repulse_at);
    logic [16:0] expv;
    expv = {1'b0, av} + {1'b0, bv} + 17'(cv);
    exp_q.push_back(expv);
    start16 = 1'b1; a16 = av; b16 = bv; cin16 = cv;
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    for (int k = 0; k <= 4; k++) begin
      if (k == repulse_at) begin
        start16 = 1'b1; a16 = 16'hAAAA;
      end else if (k == repulse_at + 1) begin
        start16 = 1'b0;
      end
      total++;
      if (busy16 !== (k < 4)) begin
        bad++;
        $display("FAIL busy16 step %0d: got %b want %b", k, busy16, (k < 4));
      end
      total++;
      if (done16 !== (k == 4)) begin
        bad++;
        $display("FAIL done16 step %0d: got %b want %b", k, done16, (k == 4));
      end
      if (k < 4) begin
        total++;
        if ({carry16, sum16} !== {last_carry16, last_sum16}) begin
          bad++;
          $display("FAIL hold16 step %0d: got %h want %h", k, {carry16, sum16},
                   {last_carry16, last_sum16});
        end
        @(negedge clk);
      end
    end
    start16 = 1'b0;
    expv = exp_q.pop_front();
    total++;
    if ({carry16, sum16} !== expv) begin
      bad++;
      $display("FAIL result16 a=%h b=%h cin=%b: got %h want %h", av, bv, cv,
               {carry16, sum16}, expv);
    end
    {last_carry16, last_sum16} = expv;
  endtask

  task automatic idle_check16(input string tag);
    @(negedge clk);
    total++;
    if (done16 !== 1'b0 || busy16 !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: got done=%b busy=%b want 0 0", tag, done16, busy16);
    end
  endtask

  // One 8-bit operation on instance sel; latency is 1 (sel 0) or 8 (sel 1).
  task automatic op8(input int sel, input logic [7:0] av, input logic [7:0] bv,
                     input logic cv);
    int lat;
    logic [8:0] expv;
    lat = (sel == 0) ? 1 : 8;
    expv = {1'b0, av} + {1'b0, bv} + 9'(cv);
    start8[sel] = 1'b1; a8[sel] = av; b8[sel] = bv; cin8[sel] = cv;
    @(negedge clk);
    start8[sel] = 1'b0;
    a8[sel] = 8'($urandom); b8[sel] = 8'($urandom); cin8[sel] = 1'($urandom);
    for (int k = 0; k < lat; k++) begin
      total++;
      if (done8[sel] !== 1'b0 || busy8[sel] !== 1'b1) begin
        bad++;
        $display("FAIL lat8 sel=%0d step %0d: got done=%b busy=%b want 0 1", sel, k,
                 done8[sel], busy8[sel]);
      end
      @(negedge clk);
    end
    total++;
    if (done8[sel] !== 1'b1 || busy8[sel] !== 1'b0 || {carry8[sel], sum8[sel]} !== expv) begin
      bad++;
      $display("FAIL result8 sel=%0d a=%h b=%h cin=%b: got done=%b busy=%b res=%h want 1 0 %h",
               sel, av, bv, cv, done8[sel], busy8[sel], {carry8[sel], sum8[sel]}, expv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy16, done16, carry16, sum16} !== '0) begin
      bad++;
      $display("FAIL reset16: got busy=%b done=%b carry=%b sum=%h want all 0",
               busy16, done16, carry16, sum16);
    end
    for (int s = 0; s < 2; s++) begin
      total++;
      if ({busy8[s], done8[s], carry8[s], sum8[s]} !== '0) begin
        bad++;
        $display("FAIL reset8 sel=%0d: got %h want 0", s,
                 {busy8[s], done8[s], carry8[s], sum8[s]});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    last_sum16 = '0; last_carry16 = 1'b0;
  endtask

  task automatic test_basic();
    op16(16'h0000, 16'h0000, 1'b0, -1);
    idle_check16("basic zero");
    op16(16'hFFFF, 16'h0001, 1'b0, -1);
    idle_check16("basic wrap");
    op16(16'h1234, 16'h4321, 1'b1, -1);
    idle_check16("basic cin");
  endtask

  task automatic test_ignored_start();
    op16(16'h00FF, 16'h0001, 1'b0, 1);
    idle_check16("ignored start");
  endtask

  task automatic test_back_to_back();
    op16(16'h0F0F, 16'hF0F1, 1'b0, -1);
    op16(16'h8000, 16'h8000, 1'b0, -1);
    op16(16'hFFFF, 16'hFFFF, 1'b1, -1);
    idle_check16("back to back");
  endtask

  task automatic test_async_reset();
    start16 = 1'b1; a16 = 16'h5555; b16 = 16'hAAAA; cin16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({busy16, done16, carry16, sum16} !== '0) begin
      bad++;
      $display("FAIL async reset: got busy=%b done=%b carry=%b sum=%h want all 0",
               busy16, done16, carry16, sum16);
    end
    @(negedge clk);
    rst = 1'b0;
    last_sum16 = '0; last_carry16 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (done16 !== 1'b0 || busy16 !== 1'b0) begin
        bad++;
        $display("FAIL post reset step %0d: got done=%b busy=%b want 0 0", k, done16, busy16);
      end
    end
    op16(16'h0003, 16'h0004, 1'b0, -1);
    idle_check16("after reset");
  endtask

  task automatic test_random16();
    for (int i = 0; i < 40; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), -1);
      if ($urandom_range(0, 1) == 0) idle_check16("random16 gap");
    end
    idle_check16("random16 end");
  endtask

  task automatic test_reconfig();
    for (int s = 0; s < 2; s++) begin
      op8(s, 8'h00, 8'h00, 1'b0);
      op8(s, 8'hFF, 8'hFF, 1'b1);
      op8(s, 8'hFF, 8'h00, 1'b1);
      op8(s, 8'h80, 8'h80, 1'b0);
      for (int i = 0; i < 150; i++) begin
        op8(s, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      start8[s] = 1'b0; a8[s] = '0; b8[s] = '0; cin8[s] = 1'b0;
    end
    test_reset();
    test_basic();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    test_random16();
    test_reconfig();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
